// File: rtl/dram_cycle_scheduler_pkg.sv
// Shared types and default timing for the FastRAM DRAM cycle scheduler.
// Holds the FSM state encoding and the bank-to-RAS decode helper.
package dram_cycle_scheduler_pkg;

   localparam int DEF_REFRESH_INTERVAL = 109;  // 15.4us at 7.09MHz
   localparam int DEF_MAX_DEBT         = 4;
   localparam int DEF_RAS_PRE          = 2;
   localparam int REF_RAS_CYCLES       = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACC_ROW,
      ST_ACC_COL,
      ST_ACC_CAS,
      ST_REF_CAS,
      ST_REF_RAS,
      ST_PRECHARGE
   } state_t;

   // Active-low row strobe pattern selecting exactly one bank.
   function automatic logic [3:0] bank_ras(input logic [1:0] bank);
      bank_ras = ~(4'b0001 << bank);
   endfunction

endpackage

// File: rtl/dram_cycle_scheduler_refresh_timer.sv
// Refresh interval timer plus a saturating count of owed refreshes.
// Debt rises each interval and falls when the scheduler enters REF_RAS.
module dram_cycle_scheduler_refresh_timer
   import dram_cycle_scheduler_pkg::*;
#(
   parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
   parameter int MAX_DEBT         = DEF_MAX_DEBT
) (
   input  logic       CLK,
   input  logic       RESETn,
   input  logic       ref_done,
   output logic [2:0] ref_debt
);

   localparam int            TIMER_W  = $clog2(REFRESH_INTERVAL);
   localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(REFRESH_INTERVAL - 1);
   localparam logic [2:0]    DEBT_MAX = 3'(MAX_DEBT);

   logic [TIMER_W-1:0] timer;
   logic               tick;

   assign tick = (timer == '0);

   // NOTE: sequential state is always written with non-blocking assignments so
   // every register samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         timer    <= RELOAD;
         ref_debt <= '0;
      end else begin
         timer <= tick ? RELOAD : timer - 1'b1;
         // A simultaneous tick and completed refresh cancel out.
         if (tick && !ref_done && ref_debt != DEBT_MAX)
            ref_debt <= ref_debt + 3'd1;
         else if (!tick && ref_done && ref_debt != '0)
            ref_debt <= ref_debt - 3'd1;
      end
   end

endmodule

// File: rtl/dram_cycle_scheduler.sv
// DRAM cycle scheduler: arbitrates Zorro II accesses against CAS-before-RAS
// refresh and drives registered RAS/CAS/mux/write-enable strobes.
module dram_cycle_scheduler
   import dram_cycle_scheduler_pkg::*;
#(
   parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
   parameter int MAX_DEBT         = DEF_MAX_DEBT,
   parameter int RAS_PRE          = DEF_RAS_PRE
) (
   input  logic       CLK,
   input  logic       RESETn,
   input  logic       ACC_REQ,
   input  logic [1:0] ACC_BANK,
   input  logic       ACC_UDSn,
   input  logic       ACC_LDSn,
   input  logic       ACC_RWn,
   output logic [3:0] RASn,
   output logic       UCASn,
   output logic       LCASn,
   output logic       MUX_COL,
   output logic       MEMWn,
   output logic       ACC_ACK,
   output logic [2:0] REF_DEBT
);

   localparam int CNT_MAX = (RAS_PRE > REF_RAS_CYCLES) ? RAS_PRE : REF_RAS_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(RAS_PRE - 1);
   localparam logic [CNT_W-1:0] REF_LOAD = CNT_W'(REF_RAS_CYCLES - 1);
   localparam logic [2:0]       DEBT_MAX = 3'(MAX_DEBT);

   state_t           state, next_state;
   logic [CNT_W-1:0] cnt, next_cnt;
   logic [1:0]       bank_q, acc_bank;
   logic             ref_done;

   logic [3:0] next_rasn;
   logic       next_ucasn, next_lcasn, next_mux_col, next_memwn, next_ack;

   // REF_CAS always advances to REF_RAS, so leaving it marks one refresh paid.
   assign ref_done = (state == ST_REF_CAS);

   dram_cycle_scheduler_refresh_timer #(
      .REFRESH_INTERVAL(REFRESH_INTERVAL),
      .MAX_DEBT        (MAX_DEBT)
   ) u_refresh_timer (
      .CLK     (CLK),
      .RESETn  (RESETn),
      .ref_done(ref_done),
      .ref_debt(REF_DEBT)
   );

   // The bank is captured while idle; ACC_ROW uses the live value at entry.
   assign acc_bank = (state == ST_IDLE) ? ACC_BANK : bank_q;

   // NOTE: every always_comb output gets a default first, so no path through
   // the case statements can leave a signal unassigned and infer a latch.
   always_comb begin
      next_state = state;
      next_cnt   = cnt;

      case (state)
         ST_IDLE: begin
            if (REF_DEBT == DEBT_MAX)  next_state = ST_REF_CAS;
            else if (ACC_REQ)          next_state = ST_ACC_ROW;
            else if (REF_DEBT != '0)   next_state = ST_REF_CAS;
         end
         ST_ACC_ROW:   next_state = ACC_REQ ? ST_ACC_COL : ST_PRECHARGE;
         ST_ACC_COL:   next_state = ACC_REQ ? ST_ACC_CAS : ST_PRECHARGE;
         ST_ACC_CAS:   if (!ACC_REQ) next_state = ST_PRECHARGE;
         ST_REF_CAS:   next_state = ST_REF_RAS;
         ST_REF_RAS:   if (cnt == '0) next_state = ST_PRECHARGE;
         ST_PRECHARGE: if (cnt == '0) next_state = ST_IDLE;
         default:      next_state = ST_IDLE;
      endcase

      if (next_state != state)
         next_cnt = (next_state == ST_REF_RAS) ? REF_LOAD : PRE_LOAD;
      else if (cnt != '0)
         next_cnt = cnt - 1'b1;
   end

   // Outputs are decoded from the state being entered so they register together with it.
   always_comb begin
      next_rasn    = 4'hF;
      next_ucasn   = 1'b1;
      next_lcasn   = 1'b1;
      next_mux_col = 1'b0;
      next_memwn   = 1'b1;
      next_ack     = 1'b0;

      case (next_state)
         ST_ACC_ROW: next_rasn = bank_ras(acc_bank);
         ST_ACC_COL: begin
            next_rasn    = bank_ras(acc_bank);
            next_mux_col = 1'b1;
            next_memwn   = ACC_RWn;
         end
         ST_ACC_CAS: begin
            next_rasn    = bank_ras(acc_bank);
            next_mux_col = 1'b1;
            next_memwn   = MEMWn;
            next_ucasn   = ACC_UDSn;
            next_lcasn   = ACC_LDSn;
            next_ack     = 1'b1;
         end
         ST_REF_CAS: begin
            next_ucasn = 1'b0;
            next_lcasn = 1'b0;
         end
         ST_REF_RAS: begin
            next_rasn  = 4'h0;
            next_ucasn = 1'b0;
            next_lcasn = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         bank_q  <= '0;
         RASn    <= 4'hF;
         UCASn   <= 1'b1;
         LCASn   <= 1'b1;
         MUX_COL <= 1'b0;
         MEMWn   <= 1'b1;
         ACC_ACK <= 1'b0;
      end else begin
         state   <= next_state;
         cnt     <= next_cnt;
         if (state == ST_IDLE) bank_q <= ACC_BANK;
         RASn    <= next_rasn;
         UCASn   <= next_ucasn;
         LCASn   <= next_lcasn;
         MUX_COL <= next_mux_col;
         MEMWn   <= next_memwn;
         ACC_ACK <= next_ack;
      end
   end

endmodule
